// File: rtl/serializer_dispatch_arbiter_pkg.sv
// rtl/serializer_dispatch_arbiter_pkg.sv - shared types and constants for the serializer dispatch arbiter
package serializer_dispatch_arbiter_pkg;

    localparam int N_DISPATCH_CORES = 4;
    localparam int N_THREADS        = 16;
    localparam int THREAD_W         = $clog2(N_THREADS);
    localparam int CNT_W            = $clog2(N_THREADS) + 1;

    // Register-bus address reserved for exposing the sticky protocol error.
    localparam logic [11:0] SERIALIZER_DISPATCH_ERR = 12'h040;

    typedef logic [$clog2(N_DISPATCH_CORES)-1:0] core_id_t;
    typedef logic [31:0]                         task_t;
    typedef logic [5:0]                          cq_slice_slot_t;
    typedef logic [THREAD_W-1:0]                 thread_id_t;

    // Contents of one per-core task slot.
    typedef struct packed {
        task_t          data;
        cq_slice_slot_t cq_slot;
        thread_id_t     thread;
    } dispatch_entry_t;

    // Number of set bits in an outstanding-thread mask.
    function automatic logic [CNT_W-1:0] popcount_threads(input logic [N_THREADS-1:0] mask);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            cnt = cnt + CNT_W'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/serializer_dispatch_arbiter_if.sv
// rtl/serializer_dispatch_arbiter_if.sv - serializer-side and core-side signal bundle
interface serializer_dispatch_arbiter_if
    import serializer_dispatch_arbiter_pkg::*;
#(
    parameter int N_CORES = N_DISPATCH_CORES
);

    logic                                s_valid;
    logic                                s_ready;
    task_t                               s_rdata;
    cq_slice_slot_t                      s_cq_slot;
    thread_id_t                          s_thread;
    logic                                unlock_valid;
    thread_id_t                          unlock_thread;
    logic           [N_CORES-1:0]        core_want;
    logic           [N_CORES-1:0]        core_task_valid;
    logic           [N_CORES-1:0]        core_task_ready;
    task_t          [N_CORES-1:0]        core_task;
    cq_slice_slot_t [N_CORES-1:0]        core_cq_slot;
    thread_id_t     [N_CORES-1:0]        core_thread;
    logic           [N_CORES-1:0]        core_finish_valid;
    thread_id_t     [N_CORES-1:0]        core_finish_thread;
    logic           [N_CORES-1:0]        core_finish_ready;
    logic           [CNT_W-1:0]          outstanding_cnt;
    logic                                protocol_error;

    modport slave (
        input  s_valid, s_rdata, s_cq_slot, s_thread,
        input  core_want, core_task_ready, core_finish_valid, core_finish_thread,
        output s_ready, unlock_valid, unlock_thread,
        output core_task_valid, core_task, core_cq_slot, core_thread,
        output core_finish_ready, outstanding_cnt, protocol_error
    );

    modport master (
        output s_valid, s_rdata, s_cq_slot, s_thread,
        output core_want, core_task_ready, core_finish_valid, core_finish_thread,
        input  s_ready, unlock_valid, unlock_thread,
        input  core_task_valid, core_task, core_cq_slot, core_thread,
        input  core_finish_ready, outstanding_cnt, protocol_error
    );

endinterface

// File: rtl/serializer_dispatch_arbiter_rr_arbiter.sv
// rtl/serializer_dispatch_arbiter_rr_arbiter.sv - round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int  N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    // First requester found scanning upward from the pointer, wrapping at N.
    always_comb begin
        int k;
        k       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(i_ptr) + i) % N;
            if (!o_any && i_req[k]) begin
                o_any = 1'b1;
                o_idx = W'(k);
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/serializer_dispatch_arbiter.sv
// rtl/serializer_dispatch_arbiter.sv - shares the serializer issue port among cores and funnels finishes back
module serializer_dispatch_arbiter
    import serializer_dispatch_arbiter_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int TILE_ID = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    serializer_dispatch_arbiter_if.slave bus
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    // Out-of-range parameters elaborate into this empty block and leave the arbiter without a tile.
    if (N_CORES < 2 || TILE_ID < 0) begin : g_illegal_params
    end

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (int'(idx) == N_CORES - 1) ? '0 : idx + 1'b1;
    endfunction

    logic            [N_CORES-1:0] r_task_valid;
    dispatch_entry_t [N_CORES-1:0] r_slot;
    logic            [IDX_W-1:0]   r_disp_ptr;
    logic            [N_CORES-1:0] r_fin_pend;
    thread_id_t      [N_CORES-1:0] r_fin_thread;
    logic            [IDX_W-1:0]   r_fin_ptr;
    logic            [N_THREADS-1:0] r_outstanding;
    logic            [CNT_W-1:0]   r_cnt;
    logic                          r_unlock_valid;
    thread_id_t                    r_unlock_thread;
    logic                          r_protocol_error;

    logic [N_CORES-1:0]   w_eligible;
    logic                 w_s_ready;
    logic                 w_disp_fire;
    logic [N_CORES-1:0]   w_disp_grant;
    logic [IDX_W-1:0]     w_disp_idx;
    logic                 w_disp_any;
    logic [N_CORES-1:0]   w_fin_grant;
    logic [IDX_W-1:0]     w_fin_idx;
    logic                 w_fin_any;
    thread_id_t           w_fin_thread;
    logic                 w_fin_legal;
    logic [N_THREADS-1:0] w_out_next;

    // A core can take work only when it asks for it and its slot is empty.
    assign w_eligible  = bus.core_want & ~r_task_valid;
    assign w_s_ready   = bus.s_valid & (|w_eligible);
    assign w_disp_fire = bus.s_valid & w_s_ready;

    rr_arbiter #(.N(N_CORES)) u_disp_arb (
        .i_req   (w_eligible),
        .i_ptr   (r_disp_ptr),
        .o_grant (w_disp_grant),
        .o_idx   (w_disp_idx),
        .o_any   (w_disp_any)
    );

    rr_arbiter #(.N(N_CORES)) u_fin_arb (
        .i_req   (r_fin_pend),
        .i_ptr   (r_fin_ptr),
        .o_grant (w_fin_grant),
        .o_idx   (w_fin_idx),
        .o_any   (w_fin_any)
    );

    assign w_fin_thread = r_fin_thread[w_fin_idx];
    assign w_fin_legal  = r_outstanding[w_fin_thread];

    // Finish clear applies before dispatch set so a same-cycle reuse of a thread stays outstanding.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_fin_any && w_fin_legal) begin
            w_out_next[w_fin_thread] = 1'b0;
        end
        if (w_disp_fire) begin
            w_out_next[bus.s_thread] = 1'b1;
        end
    end

    // Task slots: load on the granted handshake, drain when the core accepts a valid slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_task_valid <= '0;
            r_slot       <= '0;
            r_disp_ptr   <= '0;
        end else begin
            for (int c = 0; c < N_CORES; c++) begin
                if (w_disp_fire && w_disp_grant[c]) begin
                    r_task_valid[c] <= 1'b1;
                    r_slot[c]       <= '{data: bus.s_rdata, cq_slot: bus.s_cq_slot, thread: bus.s_thread};
                end else if (r_task_valid[c] && bus.core_task_ready[c]) begin
                    r_task_valid[c] <= 1'b0;
                end
            end
            if (w_disp_fire && w_disp_any) begin
                r_disp_ptr <= next_ptr(w_disp_idx);
            end
        end
    end

    // Finish slots: capture when empty, empty when picked; the picked entry becomes an unlock or an error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fin_pend       <= '0;
            r_fin_thread     <= '0;
            r_fin_ptr        <= '0;
            r_unlock_valid   <= 1'b0;
            r_unlock_thread  <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            for (int c = 0; c < N_CORES; c++) begin
                if (w_fin_any && w_fin_grant[c]) begin
                    r_fin_pend[c] <= 1'b0;
                end else if (bus.core_finish_valid[c] && !r_fin_pend[c]) begin
                    r_fin_pend[c]   <= 1'b1;
                    r_fin_thread[c] <= bus.core_finish_thread[c];
                end
            end
            r_unlock_valid <= w_fin_any & w_fin_legal;
            if (w_fin_any) begin
                r_fin_ptr       <= next_ptr(w_fin_idx);
                r_unlock_thread <= w_fin_thread;
                if (!w_fin_legal) begin
                    r_protocol_error <= 1'b1;
                end
            end
        end
    end

    // Outstanding mask and its population count move together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outstanding <= '0;
            r_cnt         <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_cnt         <= popcount_threads(w_out_next);
        end
    end

    assign bus.s_ready           = w_s_ready;
    assign bus.unlock_valid      = r_unlock_valid;
    assign bus.unlock_thread     = r_unlock_thread;
    assign bus.core_task_valid   = r_task_valid;
    assign bus.core_finish_ready = ~r_fin_pend;
    assign bus.outstanding_cnt   = r_cnt;
    assign bus.protocol_error    = r_protocol_error;

    for (genvar g = 0; g < N_CORES; g++) begin : g_core_out
        assign bus.core_task[g]    = r_slot[g].data;
        assign bus.core_cq_slot[g] = r_slot[g].cq_slot;
        assign bus.core_thread[g]  = r_slot[g].thread;
    end

endmodule

// File: tb/tb_serializer_dispatch_arbiter.sv
// tb/tb_serializer_dispatch_arbiter.sv - directed self-checking bench for serializer_dispatch_arbiter
module tb_serializer_dispatch_arbiter;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    serializer_dispatch_arbiter_if #(.N_CORES(4)) bus();

    serializer_dispatch_arbiter #(.N_CORES(4), .TILE_ID(0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_valid            = 1'b0;
        bus.s_rdata            = '0;
        bus.s_cq_slot          = '0;
        bus.s_thread           = '0;
        bus.core_want          = '0;
        bus.core_task_ready    = '0;
        bus.core_finish_valid  = '0;
        bus.core_finish_thread = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        idle_inputs();
        repeat (3) step();

        check_eq("rst_task_valid", 32'(bus.core_task_valid), 32'h0);
        check_eq("rst_fin_ready", 32'(bus.core_finish_ready), 32'hf);
        check_eq("rst_s_ready", 32'(bus.s_ready), 32'h0);
        check_eq("rst_unlock", 32'(bus.unlock_valid), 32'h0);
        check_eq("rst_cnt", 32'(bus.outstanding_cnt), 32'h0);
        check_eq("rst_perr", 32'(bus.protocol_error), 32'h0);
        rstn = 1'b1;
        step();

        // 1: reset in the middle of activity
        bus.s_valid = 1'b1; bus.s_thread = 4'd2; bus.core_want = 4'b0100;
        bus.core_finish_valid = 4'b0010; bus.core_finish_thread[1] = 4'd9;
        #1;
        check_eq("t1_s_ready", 32'(bus.s_ready), 32'h1);
        step();
        check_eq("t1_valid2", 32'(bus.core_task_valid), 32'h4);
        check_eq("t1_cnt1", 32'(bus.outstanding_cnt), 32'h1);
        bus.s_valid = 1'b0; bus.core_want = '0;
        bus.core_finish_valid = 4'b1000; bus.core_finish_thread[3] = 4'd2;
        step();
        check_eq("t1_perr_pre", 32'(bus.protocol_error), 32'h1);
        check_eq("t1_fin_ready_pre", 32'(bus.core_finish_ready), 32'h7);
        bus.core_finish_valid = '0;
        rstn = 1'b0;
        #1;
        check_eq("t1_rst_valid", 32'(bus.core_task_valid), 32'h0);
        check_eq("t1_rst_fin_ready", 32'(bus.core_finish_ready), 32'hf);
        check_eq("t1_rst_perr", 32'(bus.protocol_error), 32'h0);
        check_eq("t1_rst_cnt", 32'(bus.outstanding_cnt), 32'h0);
        step();
        rstn = 1'b1;
        step();

        // 2: round-robin fairness with all cores wanting and accepting
        bus.core_want = 4'b1111; bus.core_task_ready = 4'b1111; bus.s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.s_thread = 4'(k);
            bus.s_rdata  = 32'hA000_0000 + 32'(k);
            bus.s_cq_slot = 6'(k + 8);
            #1;
            check_eq($sformatf("t2_s_ready_%0d", k), 32'(bus.s_ready), 32'h1);
            step();
            check_eq($sformatf("t2_valid_%0d", k), 32'(bus.core_task_valid), 32'h1 << (k % 4));
            check_eq($sformatf("t2_thread_%0d", k), 32'(bus.core_thread[k % 4]), 32'(k));
            check_eq($sformatf("t2_data_%0d", k), bus.core_task[k % 4], 32'hA000_0000 + 32'(k));
            check_eq($sformatf("t2_cq_%0d", k), 32'(bus.core_cq_slot[k % 4]), 32'(k + 8));
        end
        bus.s_valid = 1'b0;
        check_eq("t2_cnt8", 32'(bus.outstanding_cnt), 32'd8);
        step();
        check_eq("t2_drained", 32'(bus.core_task_valid), 32'h0);

        // 3: backpressure from a single core
        bus.core_want = 4'b0001; bus.core_task_ready = 4'b0000;
        bus.s_valid = 1'b1; bus.s_thread = 4'd10;
        #1;
        check_eq("t3_s_ready_a", 32'(bus.s_ready), 32'h1);
        step();
        check_eq("t3_valid_a", 32'(bus.core_task_valid), 32'h1);
        check_eq("t3_thread_a", 32'(bus.core_thread[0]), 32'd10);
        bus.s_thread = 4'd11;
        #1;
        check_eq("t3_blocked_0", 32'(bus.s_ready), 32'h0);
        step();
        check_eq("t3_blocked_1", 32'(bus.s_ready), 32'h0);
        check_eq("t3_hold_thread", 32'(bus.core_thread[0]), 32'd10);
        bus.core_task_ready = 4'b0001;
        #1;
        check_eq("t3_blocked_2", 32'(bus.s_ready), 32'h0);
        step();
        check_eq("t3_drained", 32'(bus.core_task_valid), 32'h0);
        check_eq("t3_s_ready_b", 32'(bus.s_ready), 32'h1);
        step();
        check_eq("t3_valid_b", 32'(bus.core_task_valid), 32'h1);
        check_eq("t3_thread_b", 32'(bus.core_thread[0]), 32'd11);
        bus.s_valid = 1'b0; bus.core_want = '0; bus.core_task_ready = 4'b1111;
        step();
        check_eq("t3_cnt10", 32'(bus.outstanding_cnt), 32'd10);

        // retire threads 10 and 11 via cores 2 and 3 so the finish pointer wraps back to 0
        bus.core_finish_valid = 4'b1100;
        bus.core_finish_thread[2] = 4'd10; bus.core_finish_thread[3] = 4'd11;
        step();
        bus.core_finish_valid = '0;
        check_eq("t3_fin_ready", 32'(bus.core_finish_ready), 32'h3);
        step();
        check_eq("t3_unlock_a", 32'(bus.unlock_valid), 32'h1);
        check_eq("t3_unlock_thr_a", 32'(bus.unlock_thread), 32'd10);
        step();
        check_eq("t3_unlock_thr_b", 32'(bus.unlock_thread), 32'd11);
        check_eq("t3_cnt8", 32'(bus.outstanding_cnt), 32'd8);
        step();
        check_eq("t3_unlock_idle", 32'(bus.unlock_valid), 32'h0);

        // 4: four simultaneous finishes funnel out one per cycle
        bus.core_finish_valid = 4'b1111;
        for (int c = 0; c < 4; c++) bus.core_finish_thread[c] = 4'(c + 4);
        step();
        bus.core_finish_valid = '0;
        check_eq("t4_fin_ready_full", 32'(bus.core_finish_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq($sformatf("t4_unlock_%0d", c), 32'(bus.unlock_valid), 32'h1);
            check_eq($sformatf("t4_thread_%0d", c), 32'(bus.unlock_thread), 32'(c + 4));
            check_eq($sformatf("t4_cnt_%0d", c), 32'(bus.outstanding_cnt), 32'(7 - c));
        end
        step();
        check_eq("t4_unlock_idle", 32'(bus.unlock_valid), 32'h0);
        check_eq("t4_fin_ready_free", 32'(bus.core_finish_ready), 32'hf);

        // 5: finish of a thread that was never dispatched
        bus.core_finish_valid = 4'b0010; bus.core_finish_thread[1] = 4'd9;
        step();
        bus.core_finish_valid = '0;
        check_eq("t5_fin_ready_busy", 32'(bus.core_finish_ready), 32'hd);
        step();
        check_eq("t5_no_unlock", 32'(bus.unlock_valid), 32'h0);
        check_eq("t5_perr", 32'(bus.protocol_error), 32'h1);
        check_eq("t5_fin_ready_back", 32'(bus.core_finish_ready), 32'hf);
        check_eq("t5_cnt", 32'(bus.outstanding_cnt), 32'd4);
        step();
        check_eq("t5_perr_sticky", 32'(bus.protocol_error), 32'h1);

        // 6: dispatch of thread 3 in the same cycle its previous finish drains
        bus.core_finish_valid = 4'b0001; bus.core_finish_thread[0] = 4'd3;
        step();
        bus.core_finish_valid = '0;
        bus.core_want = 4'b0100; bus.core_task_ready = '0;
        bus.s_valid = 1'b1; bus.s_thread = 4'd3;
        #1;
        check_eq("t6_s_ready", 32'(bus.s_ready), 32'h1);
        step();
        bus.s_valid = 1'b0; bus.core_want = '0;
        check_eq("t6_unlock", 32'(bus.unlock_valid), 32'h1);
        check_eq("t6_unlock_thr", 32'(bus.unlock_thread), 32'd3);
        check_eq("t6_valid2", 32'(bus.core_task_valid), 32'h4);
        check_eq("t6_thread2", 32'(bus.core_thread[2]), 32'd3);
        check_eq("t6_cnt_kept", 32'(bus.outstanding_cnt), 32'd4);
        bus.core_finish_valid = 4'b0010; bus.core_finish_thread[1] = 4'd3;
        step();
        bus.core_finish_valid = '0;
        step();
        check_eq("t6_reunlock", 32'(bus.unlock_valid), 32'h1);
        check_eq("t6_reunlock_thr", 32'(bus.unlock_thread), 32'd3);
        check_eq("t6_cnt3", 32'(bus.outstanding_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
